// File: rtl/systolic_tile_sequencer.sv
// Control FSM for one systolic tile pass: weight preload, activation stream,
// pipeline flush, PISO capture and handshaked result shift-out.
module systolic_tile_sequencer #(
   parameter int DEPTH       = 4,
   parameter int K_LEN       = 8,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic                   out_ready_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   psum_clr_o,
   output logic                   w_load_en_o,
   output logic [COUNT_WIDTH-1:0] w_row_o,
   output logic                   act_en_o,
   output logic                   act_zero_o,
   output logic [COUNT_WIDTH-1:0] act_row_o,
   output logic                   piso_load_o,
   output logic                   out_valid_o,
   output logic [COUNT_WIDTH-1:0] out_row_o,
   output logic [2:0]             phase_o
);

   // state   | meaning
   // IDLE    | waiting for start
   // LOAD_W  | preload DEPTH weight rows
   // STREAM  | feed K_LEN activation rows
   // FLUSH   | feed zeros until the array drains (2*DEPTH-2 cycles)
   // CAPTURE | parallel-load the output PISO
   // SHIFT   | hand DEPTH result rows downstream under out_ready
   // DONE    | one-cycle completion pulse
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_STREAM  = 3'd2,
      S_FLUSH   = 3'd3,
      S_CAPTURE = 3'd4,
      S_SHIFT   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] ROW_LAST    = COUNT_WIDTH'(DEPTH - 1);
   localparam logic [COUNT_WIDTH-1:0] STREAM_LAST = COUNT_WIDTH'(K_LEN - 1);
   localparam logic [COUNT_WIDTH-1:0] FLUSH_LAST  = COUNT_WIDTH'(2 * DEPTH - 3);

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_i) state_d = S_LOAD_W;
         end
         S_LOAD_W: if (cnt_q == ROW_LAST) begin
            state_d = S_STREAM;
            cnt_d   = '0;
         end
         S_STREAM: if (cnt_q == STREAM_LAST) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
         end
         S_FLUSH: if (cnt_q == FLUSH_LAST) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
         end
         S_CAPTURE: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            // A stalled row keeps its index until the consumer takes it.
            if (!out_ready_i) begin
               cnt_d = cnt_q;
            end else if (cnt_q == ROW_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (abort_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
      done_o      = (state_q == S_DONE);
      psum_clr_o  = (state_q == S_LOAD_W) && (cnt_q == '0);
      w_load_en_o = (state_q == S_LOAD_W);
      w_row_o     = (state_q == S_LOAD_W) ? cnt_q : '0;
      act_en_o    = (state_q == S_STREAM) || (state_q == S_FLUSH);
      act_zero_o  = (state_q == S_FLUSH);
      act_row_o   = (state_q == S_STREAM) ? cnt_q : '0;
      piso_load_o = (state_q == S_CAPTURE);
      out_valid_o = (state_q == S_SHIFT);
      out_row_o   = (state_q == S_SHIFT) ? cnt_q : '0;
      phase_o     = state_q;
   end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Randomised scoreboard bench for systolic_tile_sequencer: a per-pass phase
// timeline is built from the phase durations and compared cycle by cycle.
module tb_systolic_tile_sequencer;

   localparam int D = 4;
   localparam int K = 8;
   localparam int W = 4;

   typedef struct {
      logic [2:0]   ph;
      logic [W-1:0] idx;
      logic         rdy;
   } step_t;

   typedef struct {
      logic [22:0] v;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst, start, abort, rdy;
   logic start2;

   logic busy, done, psum_clr, w_load_en, act_en, act_zero, piso_load, out_valid;
   logic [W-1:0] w_row, act_row, out_row;
   logic [2:0] phase;

   logic busy2, done2, psum_clr2, w_load_en2, act_en2, act_zero2, piso_load2, out_valid2;
   logic [W-1:0] w_row2, act_row2, out_row2;
   logic [2:0] phase2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   step_t tl[$];
   exp_t  sb[$];
   exp_t  sb2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_tile_sequencer #(.DEPTH(D), .K_LEN(K), .COUNT_WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .out_ready_i(rdy),
      .busy_o(busy), .done_o(done), .psum_clr_o(psum_clr), .w_load_en_o(w_load_en),
      .w_row_o(w_row), .act_en_o(act_en), .act_zero_o(act_zero), .act_row_o(act_row),
      .piso_load_o(piso_load), .out_valid_o(out_valid), .out_row_o(out_row),
      .phase_o(phase)
   );

   systolic_tile_sequencer #(.DEPTH(2), .K_LEN(1), .COUNT_WIDTH(W)) dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start2), .abort_i(1'b0), .out_ready_i(1'b1),
      .busy_o(busy2), .done_o(done2), .psum_clr_o(psum_clr2), .w_load_en_o(w_load_en2),
      .w_row_o(w_row2), .act_en_o(act_en2), .act_zero_o(act_zero2), .act_row_o(act_row2),
      .piso_load_o(piso_load2), .out_valid_o(out_valid2), .out_row_o(out_row2),
      .phase_o(phase2)
   );

   wire [22:0] vec1 = {busy, done, psum_clr, w_load_en, w_row, act_en, act_zero, act_row,
                       piso_load, out_valid, out_row, phase};
   wire [22:0] vec2 = {busy2, done2, psum_clr2, w_load_en2, w_row2, act_en2, act_zero2,
                       act_row2, piso_load2, out_valid2, out_row2, phase2};

   // Output pattern implied by a phase and the position within it.
   function automatic logic [22:0] exp_vec(logic [2:0] ph, logic [W-1:0] idx);
      logic         b, dn, pc, wl, ae, az, pl, ov;
      logic [W-1:0] wr, ar, orw;
      b   = (ph >= 3'd1) && (ph <= 3'd5);
      dn  = (ph == 3'd6);
      pc  = (ph == 3'd1) && (idx == '0);
      wl  = (ph == 3'd1);
      wr  = (ph == 3'd1) ? idx : '0;
      ae  = (ph == 3'd2) || (ph == 3'd3);
      az  = (ph == 3'd3);
      ar  = (ph == 3'd2) ? idx : '0;
      pl  = (ph == 3'd4);
      ov  = (ph == 3'd5);
      orw = (ph == 3'd5) ? idx : '0;
      return {b, dn, pc, wl, wr, ae, az, ar, pl, ov, orw, ph};
   endfunction

   // Busy part of one pass: phase durations, with optional random SHIFT stalls.
   task automatic build_pass(input int d, input int k, input bit stalls);
      step_t s;
      tl.delete();
      for (int i = 0; i < d; i++) begin
         s.ph = 3'd1; s.idx = W'(i); s.rdy = 1'($urandom_range(0, 1)); tl.push_back(s);
      end
      for (int i = 0; i < k; i++) begin
         s.ph = 3'd2; s.idx = W'(i); s.rdy = 1'($urandom_range(0, 1)); tl.push_back(s);
      end
      for (int i = 0; i < 2 * d - 2; i++) begin
         s.ph = 3'd3; s.idx = W'(i); s.rdy = 1'($urandom_range(0, 1)); tl.push_back(s);
      end
      s.ph = 3'd4; s.idx = '0; s.rdy = 1'($urandom_range(0, 1)); tl.push_back(s);
      for (int r = 0; r < d; r++) begin
         int n;
         n = stalls ? int'($urandom_range(0, 2)) : 0;
         for (int j = 0; j < n; j++) begin
            s.ph = 3'd5; s.idx = W'(r); s.rdy = 1'b0; tl.push_back(s);
         end
         s.ph = 3'd5; s.idx = W'(r); s.rdy = 1'b1; tl.push_back(s);
      end
   endtask

   task automatic step(input logic st, input logic ab, input logic rd,
                       input logic [2:0] ph, input logic [W-1:0] idx);
      exp_t e;
      start = st; abort = ab; rdy = rd;
      e.v = exp_vec(ph, idx); e.cyc = cyc;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 1) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'd0, '0);
         else                           step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0, '0);
      end
   endtask

   // abort_at < 0 runs the pass to completion.
   task automatic run_pass(input int abort_at, input bit stalls);
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 3'd0, '0);
      build_pass(D, K, stalls);
      for (int i = 0; i < tl.size(); i++) begin
         if (i == abort_at) begin
            step(1'($urandom_range(0, 1)), 1'b1, tl[i].rdy, tl[i].ph, tl[i].idx);
            return;
         end
         step(1'($urandom_range(0, 1)), 1'b0, tl[i].rdy, tl[i].ph, tl[i].idx);
      end
      step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 3'd6, '0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (vec1 !== e.v) begin
            errors++;
            $display("FAIL main_outputs cycle %0d got %h expected %h (phase got %0d exp %0d)",
                     e.cyc, vec1, e.v, vec1[2:0], e.v[2:0]);
         end
      end
      if (sb2.size() > 0) begin
         e = sb2.pop_front();
         checks++;
         if (vec2 !== e.v) begin
            errors++;
            $display("FAIL corner_outputs cycle %0d got %h expected %h (phase got %0d exp %0d)",
                     e.cyc, vec2, e.v, vec2[2:0], e.v[2:0]);
         end
      end
   end

   initial begin
      exp_t e;
      rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b0; start2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'd0, '0);

      run_pass(-1, 1'b0);
      idle_gap(2);
      run_pass(-1, 1'b1);
      idle_gap(1);
      run_pass(D + 3, 1'b0);
      idle_gap(1);
      run_pass(-1, 1'b0);
      for (int p = 0; p < 24; p++) begin
         int ab;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * D + K)) : -1;
         run_pass(ab, 1'b1);
         idle_gap(int'($urandom_range(0, 3)));
      end

      // Minimum-size array: every phase at its shortest.
      start2 = 1'b1;
      e.v = exp_vec(3'd0, '0); e.cyc = cyc; sb2.push_back(e);
      @(posedge clk); #1;
      start2 = 1'b0;
      build_pass(2, 1, 1'b0);
      for (int i = 0; i < tl.size(); i++) begin
         e.v = exp_vec(tl[i].ph, tl[i].idx); e.cyc = cyc; sb2.push_back(e);
         @(posedge clk); #1;
      end
      e.v = exp_vec(3'd6, '0); e.cyc = cyc; sb2.push_back(e);
      @(posedge clk); #1;
      e.v = exp_vec(3'd0, '0); e.cyc = cyc; sb2.push_back(e);
      @(posedge clk); #1;

      @(negedge clk); #1;
      checks++;
      if (sb.size() + sb2.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left %0d required 0", sb.size() + sb2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
